kyber_poly_engine: RTL and testbench
====================================

KYBER_POLY_ENGINE -- requirements
Module: kyber_poly_engine

Interface
REQ-001 Parameter Q, default 3329, Kyber modulus.
REQ-002 Parameter N, default 256, coefficients per polynomial.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 reg_en  in  1  control-bus access enable.
REQ-006 reg_we  in  4  control-bus byte write enables; any bit set = write.
REQ-007 reg_addr  in  13  control-bus word address.
REQ-008 reg_din  in  32  control-bus write data.
REQ-009 reg_dout  out  32  control-bus read data, registered.
REQ-010 in_en  out  1  input-memory read enable.
REQ-011 in_addr  out  10  input-memory word address.
REQ-012 in_dout  in  32  input-memory read data, valid one cycle after in_en/in_addr.
REQ-013 out_en  out  1  output-memory enable.
REQ-014 out_we  out  4  output-memory byte write enables.
REQ-015 out_addr  out  10  output-memory word address.
REQ-016 out_din  out  32  output-memory write data.

Function
REQ-017 Register map: addr 1 START (write, bit0); addr 3 MODE (read/write, bits[1:0]); addr 4 STATUS (read: bit0 done, bit1 error); addr 5 BUSY (read, bit0); all other reads return 0; writes elsewhere are ignored.
REQ-018 reg_dout updates on the edge after reg_en=1 with reg_we=0, and holds otherwise.
REQ-019 A MODE write is ignored while busy.
REQ-020 A START write with din[0]=1 in IDLE or DONE clears done/error, latches MODE, sets index i=0, and enters RD_A; while busy it is ignored; din[0]=0 has no effect.
REQ-021 FSM states are IDLE, RD_A, RD_B, LATCH, WR, DONE.
REQ-022 RD_A drives in_en=1 and in_addr=i; next state is RD_B for modes 1/2 and LATCH for mode 0.
REQ-023 RD_B drives in_en=1, in_addr=N+i, and captures operand a from in_dout; next state is LATCH.
REQ-024 LATCH captures operand b from in_dout (mode 0: captures a); next state is WR.
REQ-025 WR drives out_en=1, out_we=4'hF, out_addr=i, out_din={20'b0,r}; if i=N-1 the next state is DONE, else i+1 and RD_A.
REQ-026 Operand reduction: x = in_dout[11:0]; if x>=Q, x-Q.
REQ-027 Mode 0 computes r=a.
REQ-028 Mode 1 computes r=(a+b), minus Q if >=Q.
REQ-029 Mode 2 computes r=a-b, plus Q if a<b.
REQ-030 In all modes r is 12 bits and in [0,Q-1].
REQ-031 Mode 3 is reserved: START goes directly to DONE with error=1 and no memory access.
REQ-032 Latency from the START write edge to done=1 is exactly 3N+1 cycles in mode 0 and 4N+1 cycles in modes 1/2.
REQ-033 BUSY=1 in every state except IDLE and DONE.
REQ-034 DONE holds done=1 until the next START or reset.
REQ-035 in_en=0 outside RD_A/RD_B; out_en=0 and out_we=0 outside WR.

Reset
REQ-036 While rst_n=0 at a clock edge: state IDLE, i=0, MODE=0, done=0, error=0, reg_dout=0, all memory outputs 0.
REQ-037 Reset asserted mid-operation aborts at that edge; no further memory writes occur, and already-written words are not restored.

Verification
REQ-038 Input mem[k]=k (k=0..1023), MODE=0, START -> out[i]=i for i=0..255, done at cycle 769, error=0.
REQ-039 Same data, MODE=1 -> out[i]=2i+256, done at cycle 1025.
REQ-040 Same data, MODE=2 -> out[i]=3073 for all i.
REQ-041 mem[0]=4095, mem[256]=3328, MODE=1 -> out[0]=(766+3328)-3329=765; mem[0]=3328/mem[256]=3328, MODE=1 -> out[0]=3327.
REQ-042 MODE=3, START -> STATUS=3 after 1 cycle, no out_en pulses.
REQ-043 START re-written and MODE changed mid-run -> both ignored; rst_n=0 mid-run -> next edge all outputs 0, STATUS=0, subsequent START runs normally.

Source files
------------

// File: rtl/kyber_poly_engine.sv
// Kyber coefficient engine: streams N coefficient pairs from the input memory,
// applies a mod-Q operation per MODE, and writes N results to the output memory.
module kyber_poly_engine #(
  parameter int Q = 3329,
  parameter int N = 256
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        reg_en_i,
  input  logic [3:0]  reg_we_i,
  input  logic [12:0] reg_addr_i,
  input  logic [31:0] reg_din_i,
  output logic [31:0] reg_dout_o,
  output logic        in_en_o,
  output logic [9:0]  in_addr_o,
  input  logic [31:0] in_dout_i,
  output logic        out_en_o,
  output logic [3:0]  out_we_o,
  output logic [9:0]  out_addr_o,
  output logic [31:0] out_din_o
);

  // state   | meaning
  // IDLE    | waiting for START
  // RD_A    | read address i issued
  // RD_B    | capture a, read address N+i issued (modes 1/2)
  // LATCH   | capture b (mode 0: capture a)
  // WR      | write r to output word i
  // DONE    | finished; done flag held until next START
  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_LATCH, S_WR, S_DONE} state_t;

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [11:0] Q12 = 12'(Q);
  localparam logic [12:0] Q13 = 13'(Q);

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    run_mode_q, run_mode_d;
  logic [11:0]   a_q, a_d, b_q, b_d;
  logic          done_q, done_d, error_q, error_d;
  logic [31:0]   reg_dout_q, reg_dout_d;

  logic          wr_acc, rd_acc, busy, start_acc;
  logic [11:0]   x_red, r;
  logic [11:0]   x_raw;
  logic [12:0]   sum;
  logic          unused_bits;

  assign unused_bits = ^{in_dout_i[31:12], reg_din_i[31:2]};

  assign wr_acc    = reg_en_i && (reg_we_i != 4'h0);
  assign rd_acc    = reg_en_i && (reg_we_i == 4'h0);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign start_acc = wr_acc && (reg_addr_i == 13'd1) && reg_din_i[0] && !busy;

  assign x_raw = in_dout_i[11:0];
  assign x_red = (x_raw >= Q12) ? x_raw - Q12 : x_raw;
  assign sum   = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    r = a_q;
    case (run_mode_q)
      2'd1:    r = (sum >= Q13) ? 12'(sum - Q13) : sum[11:0];
      2'd2:    r = (a_q >= b_q) ? a_q - b_q : a_q + Q12 - b_q;
      default: r = a_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    run_mode_d = run_mode_q;
    a_d        = a_q;
    b_d        = b_q;
    done_d     = done_q;
    error_d    = error_q;
    in_en_o    = 1'b0;
    in_addr_o  = 10'd0;
    out_en_o   = 1'b0;
    out_we_o   = 4'h0;
    out_addr_o = 10'd0;
    out_din_o  = 32'd0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) done_d = 1'b1;
        if (start_acc) begin
          done_d     = 1'b0;
          error_d    = 1'b0;
          run_mode_d = mode_q;
          i_d        = '0;
          // Reserved mode skips all memory traffic and reports an error.
          if (mode_q == 2'd3) begin
            state_d = S_DONE;
            error_d = 1'b1;
          end else begin
            state_d = S_RD_A;
          end
        end
      end
      S_RD_A: begin
        in_en_o   = 1'b1;
        in_addr_o = 10'(i_q);
        state_d   = (run_mode_q == 2'd0) ? S_LATCH : S_RD_B;
      end
      S_RD_B: begin
        in_en_o   = 1'b1;
        in_addr_o = 10'(N) + 10'(i_q);
        a_d       = x_red;
        state_d   = S_LATCH;
      end
      S_LATCH: begin
        if (run_mode_q == 2'd0) a_d = x_red;
        else                    b_d = x_red;
        state_d = S_WR;
      end
      S_WR: begin
        out_en_o   = 1'b1;
        out_we_o   = 4'hF;
        out_addr_o = 10'(i_q);
        out_din_o  = {20'd0, r};
        if (i_q == LAST) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = S_RD_A;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mode_d     = mode_q;
    reg_dout_d = reg_dout_q;
    if (wr_acc && (reg_addr_i == 13'd3) && !busy) mode_d = reg_din_i[1:0];
    if (rd_acc) begin
      case (reg_addr_i)
        13'd3:   reg_dout_d = {30'd0, mode_q};
        13'd4:   reg_dout_d = {30'd0, error_q, done_q};
        13'd5:   reg_dout_d = {31'd0, busy};
        default: reg_dout_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      mode_q     <= 2'd0;
      run_mode_q <= 2'd0;
      a_q        <= 12'd0;
      b_q        <= 12'd0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      reg_dout_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      mode_q     <= mode_d;
      run_mode_q <= run_mode_d;
      a_q        <= a_d;
      b_q        <= b_d;
      done_q     <= done_d;
      error_q    <= error_d;
      reg_dout_q <= reg_dout_d;
    end
  end

  assign reg_dout_o = reg_dout_q;

endmodule

// File: tb/tb_kyber_poly_engine.sv
// Directed bench for kyber_poly_engine: input/output memory models, a mod-Q
// reference model, and a per-cycle write checker.
module tb_kyber_poly_engine;
  localparam int Q = 3329;
  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_en;
  logic [3:0]  reg_we;
  logic [12:0] reg_addr;
  logic [31:0] reg_din;
  logic [31:0] reg_dout;
  logic        in_en;
  logic [9:0]  in_addr;
  logic [31:0] in_dout;
  logic        out_en;
  logic [3:0]  out_we;
  logic [9:0]  out_addr;
  logic [31:0] out_din;

  int in_mem  [1024];
  int out_mem [1024];
  int total = 0;
  int bad = 0;
  int exp_mode = 0;
  int exp_idx = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  always #5 clk = ~clk;

  kyber_poly_engine #(.Q(Q), .N(N)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .reg_en_i(reg_en), .reg_we_i(reg_we), .reg_addr_i(reg_addr),
    .reg_din_i(reg_din), .reg_dout_o(reg_dout),
    .in_en_o(in_en), .in_addr_o(in_addr), .in_dout_i(in_dout),
    .out_en_o(out_en), .out_we_o(out_we), .out_addr_o(out_addr), .out_din_o(out_din)
  );

  // Synchronous-read input memory and byte-enable output memory.
  always @(posedge clk) begin
    if (in_en) in_dout <= in_mem[in_addr];
    if (out_en && out_we == 4'hF) out_mem[out_addr] <= out_din;
  end

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int red(input int w);
    return (w & 4095) % Q;
  endfunction

  function automatic int model(input int mode, input int k);
    int a, b;
    if (k < 0 || k >= N) return -1;
    a = red(in_mem[k]);
    b = red(in_mem[N + k]);
    case (mode)
      0:       return a;
      1:       return (a + b) % Q;
      2:       return (a - b + Q) % Q;
      default: return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_en) rd_cnt++;
      if (out_en) begin
        chk("wr_we", int'(out_we), 15);
        chk("wr_addr", int'(out_addr), exp_idx);
        chk("wr_data", int'(out_din), model(exp_mode, exp_idx));
        exp_idx++;
        wr_cnt++;
      end else begin
        chk("idle_we", int'(out_we), 0);
      end
    end
  end

  task automatic bus_write(input int addr, input int data);
    reg_en = 1'b1; reg_we = 4'hF; reg_addr = 13'(addr); reg_din = 32'(data);
    @(posedge clk); #1;
    reg_en = 1'b0; reg_we = 4'h0;
  endtask

  task automatic bus_read(input int addr, output int data);
    reg_en = 1'b1; reg_we = 4'h0; reg_addr = 13'(addr);
    @(posedge clk); #1;
    data = int'(reg_dout);
    reg_en = 1'b0;
  endtask

  task automatic identity_mem();
    for (int k = 0; k < 1024; k++) in_mem[k] = k;
  endtask

  task automatic run(input int mode, input bit disturb);
    int lat, cnt, st, wr0, rd0, exp_l;
    exp_l = (mode == 3) ? 1 : ((mode == 0) ? 3 * N + 1 : 4 * N + 1);
    bus_write(3, mode);
    exp_mode = mode; exp_idx = 0; wr0 = wr_cnt; rd0 = rd_cnt;
    bus_write(1, 1);
    cnt = 0;
    if (disturb) begin
      bus_write(3, 2);
      bus_write(1, 1);
      bus_read(3, st); chk("mode_locked", st, mode);
      bus_read(5, st); chk("busy_mid", st, 1);
      cnt = 4;
    end
    // STATUS reads are registered: the flag shows one edge after done is set.
    lat = -1;
    reg_en = 1'b1; reg_we = 4'h0; reg_addr = 13'd4;
    while (lat < 0 && cnt < 5 * N + 50) begin
      @(posedge clk); #1;
      cnt++;
      if (reg_dout[0]) lat = cnt - 1;
    end
    reg_en = 1'b0;
    chk("done_latency", lat, exp_l);
    bus_read(4, st); chk("status", st, (mode == 3) ? 3 : 1);
    chk("write_count", wr_cnt - wr0, (mode == 3) ? 0 : N);
    if (mode == 3) chk("read_count", rd_cnt - rd0, 0);
    bus_read(5, st); chk("busy_after", st, 0);
  endtask

  initial begin
    int st, wr0;
    rst_n = 1'b0; reg_en = 1'b0; reg_we = 4'h0; reg_addr = 13'd0; reg_din = 32'd0;
    in_dout = 32'd0;
    identity_mem();
    for (int k = 0; k < 1024; k++) out_mem[k] = -1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_en", int'(in_en), 0);
    chk("rst_out_en", int'(out_en), 0);
    chk("rst_out_we", int'(out_we), 0);
    chk("rst_reg_dout", int'(reg_dout), 0);
    rst_n = 1'b1;
    bus_read(3, st); chk("rst_mode", st, 0);
    bus_read(4, st); chk("rst_status", st, 0);
    bus_read(5, st); chk("rst_busy", st, 0);
    bus_write(7, 32'hFFFF);
    bus_read(7, st); chk("unmapped_read", st, 0);
    bus_read(1, st); chk("start_read", st, 0);

    chk("model_m0", model(0, 17), 17);
    chk("model_m1", model(1, 10), 276);
    chk("model_m2", model(2, 3), 3073);

    run(0, 1'b0); chk("out_m0_255", out_mem[255], 255);
    run(1, 1'b0); chk("out_m1_10", out_mem[10], 276);
    run(2, 1'b0); chk("out_m2_200", out_mem[200], 3073);
    run(1, 1'b1); chk("out_dist_7", out_mem[7], 270);

    in_mem[0] = 4095; in_mem[256] = 3328;
    chk("model_sat", model(1, 0), 765);
    run(1, 1'b0); chk("out_sat_0", out_mem[0], 765);
    in_mem[0] = 3328;
    run(1, 1'b0); chk("out_sat2_0", out_mem[0], 3327);
    run(3, 1'b0);

    // Abort a mode-0 run with reset, then confirm a clean restart.
    identity_mem();
    bus_write(3, 0);
    exp_mode = 0; exp_idx = 0;
    bus_write(1, 1);
    repeat (98) @(posedge clk);
    #1;
    bus_read(5, st); chk("busy_pre_rst", st, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_in_en", int'(in_en), 0);
    chk("mid_rst_in_addr", int'(in_addr), 0);
    chk("mid_rst_out_en", int'(out_en), 0);
    chk("mid_rst_out_we", int'(out_we), 0);
    chk("mid_rst_out_addr", int'(out_addr), 0);
    chk("mid_rst_out_din", int'(out_din), 0);
    chk("mid_rst_reg_dout", int'(reg_dout), 0);
    wr0 = wr_cnt;
    rst_n = 1'b1;
    bus_read(4, st); chk("post_rst_status", st, 0);
    bus_read(5, st); chk("post_rst_busy", st, 0);
    bus_read(3, st); chk("post_rst_mode", st, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("no_writes_after_rst", wr_cnt - wr0, 0);
    run(0, 1'b0); chk("out_restart_99", out_mem[99], 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
